// File: rtl/blit_pkg.sv
// Shared types and widths for the blitter's SDRAM arbiter.
package blit_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WR,
        ARB_RD,
        ARB_RD_DATA
    } arb_state_t;

endpackage

// File: rtl/blit_sdram_arb.sv
// Merges the blitter write and read ports onto one SDRAM master slot,
// one transaction at a time, alternating fairly on contention.
module blit_sdram_arb #(
    parameter int ADDR_W = blit_pkg::ADDR_W,
    parameter int DATA_W = blit_pkg::DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  blitw_sdram_req,
    input  logic [ADDR_W-1:0]     blitw_sdram_addr,
    input  logic [DATA_W-1:0]     blitw_sdram_wdata,
    input  logic [DATA_W/8-1:0]   blitw_sdram_byte_enable,
    output logic                  blitw_sdram_ack,

    input  logic                  blitr_sdram_req,
    input  logic [ADDR_W-1:0]     blitr_sdram_addr,
    output logic                  blitr_sdram_ack,
    output logic [DATA_W-1:0]     blitr_sdram_rdata,
    output logic                  blitr_sdram_rdvalid,
    output logic                  blitr_sdram_complete,

    output logic                  sdram_req,
    output logic                  sdram_write,
    output logic [ADDR_W-1:0]     sdram_addr,
    output logic [DATA_W-1:0]     sdram_wdata,
    output logic [DATA_W/8-1:0]   sdram_byte_enable,
    input  logic                  sdram_ack,
    input  logic [DATA_W-1:0]     sdram_rdata,
    input  logic                  sdram_rdvalid,
    input  logic                  sdram_complete,

    output logic                  arb_busy
);

    import blit_pkg::*;

    arb_state_t state_q, state_d;
    logic       last_wr_q, last_wr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (blitw_sdram_req && blitr_sdram_req)
                    state_d = last_wr_q ? ARB_RD : ARB_WR;
                else if (blitw_sdram_req)
                    state_d = ARB_WR;
                else if (blitr_sdram_req)
                    state_d = ARB_RD;
            end
            ARB_WR: begin
                if (sdram_ack) begin
                    state_d   = ARB_IDLE;
                    last_wr_d = 1'b1;
                end
            end
            ARB_RD: begin
                if (sdram_ack) begin
                    state_d   = ARB_RD_DATA;
                    last_wr_d = 1'b0;
                end
            end
            ARB_RD_DATA: begin
                if (sdram_complete)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        sdram_req            = 1'b0;
        sdram_write          = 1'b0;
        sdram_addr           = '0;
        sdram_wdata          = '0;
        sdram_byte_enable    = '0;
        blitw_sdram_ack      = 1'b0;
        blitr_sdram_ack      = 1'b0;
        blitr_sdram_rdvalid  = 1'b0;
        blitr_sdram_complete = 1'b0;
        unique case (state_q)
            ARB_WR: begin
                sdram_req         = blitw_sdram_req;
                sdram_write       = 1'b1;
                sdram_addr        = blitw_sdram_addr;
                sdram_wdata       = blitw_sdram_wdata;
                sdram_byte_enable = blitw_sdram_byte_enable;
                blitw_sdram_ack   = sdram_ack;
            end
            ARB_RD: begin
                sdram_req       = blitr_sdram_req;
                sdram_addr      = blitr_sdram_addr;
                blitr_sdram_ack = sdram_ack;
            end
            ARB_RD_DATA: begin
                blitr_sdram_rdvalid  = sdram_rdvalid;
                blitr_sdram_complete = sdram_complete;
            end
            default: ;
        endcase
    end

    assign blitr_sdram_rdata = sdram_rdata;
    assign arb_busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_blit_sdram_arb.sv
// Self-checking bench for blit_sdram_arb: ownership model plus a reactive
// SDRAM controller and queue-driven clients.
module tb_blit_sdram_arb;

    logic        clock;
    logic        reset;
    logic        blitw_sdram_req;
    logic [25:0] blitw_sdram_addr;
    logic [31:0] blitw_sdram_wdata;
    logic [3:0]  blitw_sdram_byte_enable;
    logic        blitw_sdram_ack;
    logic        blitr_sdram_req;
    logic [25:0] blitr_sdram_addr;
    logic        blitr_sdram_ack;
    logic [31:0] blitr_sdram_rdata;
    logic        blitr_sdram_rdvalid;
    logic        blitr_sdram_complete;
    logic        sdram_req;
    logic        sdram_write;
    logic [25:0] sdram_addr;
    logic [31:0] sdram_wdata;
    logic [3:0]  sdram_byte_enable;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic        sdram_rdvalid;
    logic        sdram_complete;
    logic        arb_busy;

    blit_sdram_arb #(.ADDR_W(26), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .blitw_sdram_req(blitw_sdram_req), .blitw_sdram_addr(blitw_sdram_addr),
        .blitw_sdram_wdata(blitw_sdram_wdata), .blitw_sdram_byte_enable(blitw_sdram_byte_enable),
        .blitw_sdram_ack(blitw_sdram_ack),
        .blitr_sdram_req(blitr_sdram_req), .blitr_sdram_addr(blitr_sdram_addr),
        .blitr_sdram_ack(blitr_sdram_ack), .blitr_sdram_rdata(blitr_sdram_rdata),
        .blitr_sdram_rdvalid(blitr_sdram_rdvalid), .blitr_sdram_complete(blitr_sdram_complete),
        .sdram_req(sdram_req), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata), .sdram_byte_enable(sdram_byte_enable),
        .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid),
        .sdram_complete(sdram_complete), .arb_busy(arb_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [25:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_item_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    wr_item_t    wq[$];
    logic [25:0] rq[$];

    int ackDelay = 0;
    int numBeats = 4;
    int waitCnt = 0;
    int beatsLeft = 0;
    int nextBeat = 1;
    bit spurious = 0;

    logic [25:0] wAckAddr[$];
    int          wAckCyc[$];
    byte         ackOrder[$];
    logic [31:0] beatLog[$];
    int          completeCnt = 0;
    int          wReqCycles = 0;
    int          overlapErr = 0;
    bit          readOutstanding = 0;
    bit          prevWack = 0;
    bit          prevComplete = 0;

    // Model: who owns the master port, whether the read has been accepted,
    // and whether the writer won the previous grant.
    int mOwner = 0;
    bit mData = 0;
    bit mWrLast = 0;
    bit mValid = 0;
    bit isW, isR, isD;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expVal);
        tests++;
        if (act !== expVal) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expVal, cyc);
        end
    endtask

    // The model advances on the same edge as the DUT, from the inputs present there.
    always @(posedge clock) begin
        if (reset) begin
            mOwner  = 0;
            mData   = 0;
            mWrLast = 0;
            mValid  = 1;
        end else if (mValid) begin
            if (mOwner == 0) begin
                if (blitw_sdram_req && (!blitr_sdram_req || !mWrLast))
                    mOwner = 1;
                else if (blitr_sdram_req)
                    mOwner = 2;
            end else if (mOwner == 1) begin
                checkOutput("wreq_held", blitw_sdram_req, 1);
                if (sdram_ack) begin
                    mOwner  = 0;
                    mWrLast = 1;
                end
            end else if (!mData) begin
                checkOutput("rreq_held", blitr_sdram_req, 1);
                if (sdram_ack) begin
                    mData   = 1;
                    mWrLast = 0;
                end
            end else if (sdram_complete) begin
                mOwner = 0;
                mData  = 0;
            end
        end
    end

    // Every cycle the DUT outputs are compared against the model's view.
    always @(negedge clock) begin
        if (mValid) begin
            isW = (mOwner == 1);
            isR = (mOwner == 2) && !mData;
            isD = (mOwner == 2) && mData;
            checkOutput("m_req", sdram_req, isW ? blitw_sdram_req : (isR ? blitr_sdram_req : 1'b0));
            checkOutput("m_write", sdram_write, isW);
            checkOutput("m_addr", sdram_addr, isW ? blitw_sdram_addr : (isR ? blitr_sdram_addr : 26'd0));
            checkOutput("m_wdata", sdram_wdata, isW ? blitw_sdram_wdata : 32'd0);
            checkOutput("m_be", sdram_byte_enable, isW ? blitw_sdram_byte_enable : 4'd0);
            checkOutput("m_wack", blitw_sdram_ack, isW && sdram_ack);
            checkOutput("m_rack", blitr_sdram_ack, isR && sdram_ack);
            checkOutput("m_rdvalid", blitr_sdram_rdvalid, isD && sdram_rdvalid);
            checkOutput("m_complete", blitr_sdram_complete, isD && sdram_complete);
            checkOutput("m_rdata", blitr_sdram_rdata, sdram_rdata);
            checkOutput("m_busy", arb_busy, mOwner != 0);
        end
    end

    // Clients present the head of their queue and hold it until acked.
    task automatic applyStimulus();
        if (wq.size() != 0) begin
            blitw_sdram_req         = 1'b1;
            blitw_sdram_addr        = wq[0].addr;
            blitw_sdram_wdata       = wq[0].data;
            blitw_sdram_byte_enable = wq[0].be;
        end else begin
            blitw_sdram_req         = 1'b0;
            blitw_sdram_addr        = '0;
            blitw_sdram_wdata       = '0;
            blitw_sdram_byte_enable = '0;
        end
        blitr_sdram_req  = (rq.size() != 0);
        blitr_sdram_addr = (rq.size() != 0) ? rq[0] : 26'd0;
    endtask

    task automatic controllerRespond();
        sdram_ack      = 1'b0;
        sdram_rdvalid  = 1'b0;
        sdram_complete = 1'b0;
        sdram_rdata    = '0;
        if (beatsLeft > 0) begin
            sdram_rdvalid  = 1'b1;
            sdram_rdata    = nextBeat;
            nextBeat++;
            beatsLeft--;
            sdram_complete = (beatsLeft == 0);
        end else if (sdram_req) begin
            if (waitCnt >= ackDelay) begin
                sdram_ack = 1'b1;
                waitCnt   = 0;
                if (!sdram_write) begin
                    beatsLeft = numBeats;
                    nextBeat  = 1;
                end
            end else begin
                waitCnt++;
            end
        end
    endtask

    task automatic observe();
        if (prevWack) checkOutput("idle_after_wack", arb_busy, 0);
        if (prevComplete) checkOutput("idle_after_complete", arb_busy, 0);
        prevWack     = blitw_sdram_ack;
        prevComplete = blitr_sdram_complete;
        if (sdram_req && sdram_write) begin
            wReqCycles++;
            if (readOutstanding) overlapErr++;
        end
        if (blitw_sdram_ack) begin
            wAckAddr.push_back(sdram_addr);
            wAckCyc.push_back(cyc);
            ackOrder.push_back(8'h57);
            if (wq.size() != 0) void'(wq.pop_front());
        end
        if (blitr_sdram_ack) begin
            ackOrder.push_back(8'h52);
            readOutstanding = 1;
            if (rq.size() != 0) void'(rq.pop_front());
        end
        if (blitr_sdram_rdvalid) beatLog.push_back(blitr_sdram_rdata);
        if (blitr_sdram_complete) begin
            completeCnt++;
            readOutstanding = 0;
        end
    endtask

    task automatic stepR(input bit rst);
        @(posedge clock);
        #1;
        cyc++;
        reset = rst;
        if (rst) begin
            wq.delete();
            rq.delete();
            beatsLeft       = 0;
            waitCnt         = 0;
            readOutstanding = 0;
            prevWack        = 0;
            prevComplete    = 0;
        end
        applyStimulus();
        #1;
        controllerRespond();
        if (spurious) begin
            sdram_ack      = 1'b1;
            sdram_rdvalid  = 1'b1;
            sdram_complete = 1'b1;
            sdram_rdata    = 32'hBAD0BAD0;
            spurious       = 0;
        end
        #1;
        observe();
    endtask

    task automatic runUntilIdle(input int maxC);
        int n;
        stepR(0);
        n = 1;
        while ((wq.size() != 0 || rq.size() != 0 || beatsLeft != 0 || arb_busy) && n < maxC) begin
            stepR(0);
            n++;
        end
        if (wq.size() != 0 || rq.size() != 0 || beatsLeft != 0 || arb_busy) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: still busy after %0d cycles, required idle", maxC);
        end
    endtask

    task automatic clearLogs();
        wAckAddr.delete();
        wAckCyc.delete();
        ackOrder.delete();
        beatLog.delete();
        completeCnt = 0;
        wReqCycles  = 0;
        overlapErr  = 0;
    endtask

    initial begin
        int startCyc;
        int n;
        wr_item_t it;

        reset = 1'b1;
        blitw_sdram_req = 0; blitw_sdram_addr = 0; blitw_sdram_wdata = 0; blitw_sdram_byte_enable = 0;
        blitr_sdram_req = 0; blitr_sdram_addr = 0;
        sdram_ack = 0; sdram_rdata = 0; sdram_rdvalid = 0; sdram_complete = 0;

        stepR(1);
        stepR(1);
        stepR(0);
        checkOutput("reset_busy", arb_busy, 0);
        checkOutput("reset_req", sdram_req, 0);
        checkOutput("reset_wack", blitw_sdram_ack, 0);

        // Single write, controller waits 3 cycles before accepting.
        clearLogs();
        ackDelay = 3;
        it.addr = 26'h0000100; it.data = 32'hDEADBEEF; it.be = 4'hF;
        wq.push_back(it);
        startCyc = cyc;
        runUntilIdle(40);
        checkOutput("wr_ack_count", wAckCyc.size(), 1);
        if (wAckCyc.size() == 1) begin
            checkOutput("wr_ack_latency", wAckCyc[0] - startCyc, 5);
            checkOutput("wr_ack_addr", wAckAddr[0], 26'h0000100);
        end
        checkOutput("wr_req_cycles", wReqCycles, 4);

        // Single read, 4 beats with complete on the last.
        clearLogs();
        ackDelay = 2;
        numBeats = 4;
        rq.push_back(26'h0000200);
        runUntilIdle(40);
        checkOutput("rd_beats", beatLog.size(), 4);
        for (int i = 0; i < 4 && i < beatLog.size(); i++)
            checkOutput("rd_beat_val", beatLog[i], i + 1);
        checkOutput("rd_complete", completeCnt, 1);

        // Contention from the same cycle: W, R, W, R.
        clearLogs();
        ackDelay = 1;
        numBeats = 2;
        it.addr = 26'h10; it.data = 32'h11111111; it.be = 4'h3;
        wq.push_back(it);
        it.addr = 26'h11; it.data = 32'h22222222; it.be = 4'hC;
        wq.push_back(it);
        rq.push_back(26'h20);
        rq.push_back(26'h21);
        runUntilIdle(80);
        checkOutput("cont_acks", ackOrder.size(), 4);
        for (int i = 0; i < 4 && i < ackOrder.size(); i++)
            checkOutput("cont_order", ackOrder[i], (i % 2 == 1) ? 8'h52 : 8'h57);
        checkOutput("cont_overlap", overlapErr, 0);
        checkOutput("cont_beats", beatLog.size(), 4);

        // Spurious controller strobes while idle.
        clearLogs();
        spurious = 1;
        stepR(0);
        checkOutput("spur_wack", blitw_sdram_ack, 0);
        checkOutput("spur_rack", blitr_sdram_ack, 0);
        checkOutput("spur_rdvalid", blitr_sdram_rdvalid, 0);
        checkOutput("spur_complete", blitr_sdram_complete, 0);
        checkOutput("spur_rdata", blitr_sdram_rdata, 32'hBAD0BAD0);
        stepR(0);
        checkOutput("spur_idle", arb_busy, 0);

        // Reset in the middle of a read's data phase, then a fresh read.
        clearLogs();
        ackDelay = 0;
        numBeats = 4;
        rq.push_back(26'h0000300);
        n = 0;
        while (beatLog.size() < 2 && n < 20) begin
            stepR(0);
            n++;
        end
        checkOutput("rst_two_beats", beatLog.size(), 2);
        stepR(1);
        stepR(0);
        checkOutput("rst_busy", arb_busy, 0);
        checkOutput("rst_req", sdram_req, 0);
        checkOutput("rst_write", sdram_write, 0);
        checkOutput("rst_addr", sdram_addr, 0);
        checkOutput("rst_rdvalid", blitr_sdram_rdvalid, 0);
        checkOutput("rst_complete", blitr_sdram_complete, 0);
        clearLogs();
        rq.push_back(26'h0000400);
        runUntilIdle(40);
        checkOutput("rst_fresh_beats", beatLog.size(), 4);
        checkOutput("rst_fresh_complete", completeCnt, 1);

        // Stream of 16 writes against a zero-wait controller.
        clearLogs();
        ackDelay = 0;
        for (int i = 0; i < 16; i++) begin
            it.addr = 26'h1000 + i; it.data = 32'hA000 + i; it.be = i[3:0];
            wq.push_back(it);
        end
        runUntilIdle(100);
        checkOutput("stream_acks", wAckCyc.size(), 16);
        for (int i = 0; i < wAckCyc.size() && i < 16; i++) begin
            checkOutput("stream_addr", wAckAddr[i], 26'h1000 + i);
            if (i > 0) checkOutput("stream_spacing", wAckCyc[i] - wAckCyc[i-1], 2);
        end

        stepR(0);
        stepR(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blit_sdram_arb.md
# blit_sdram_arb

Two-client SDRAM arbiter that sits directly downstream of `blit_top`. It merges the blitter's write port (`blitw_*`) and read port (`blitr_*`) onto a single SDRAM master port. That master port feeds one client slot of the system SDRAM controller. The arbiter keeps at most one transaction outstanding, alternates fairly when both clients request, and routes read data back to the read client.

## Interface
Parameters:
- ADDR_W, 26, SDRAM word-address width.
- DATA_W, 32, data width. Byte enables are DATA_W/8.

Ports (`clock` rising edge; `reset` is synchronous and active-high):
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- blitw_sdram_req  in  1  write request; held with addr/wdata/byte_enable until ack
- blitw_sdram_addr  in  ADDR_W  write address
- blitw_sdram_wdata  in  DATA_W  write data
- blitw_sdram_byte_enable  in  4  write byte lanes
- blitw_sdram_ack  out  1  one-cycle write accept
- blitr_sdram_req  in  1  read request; held with addr until ack
- blitr_sdram_addr  in  ADDR_W  read address
- blitr_sdram_ack  out  1  one-cycle read accept
- blitr_sdram_rdata  out  DATA_W  read data
- blitr_sdram_rdvalid  out  1  read beat valid
- blitr_sdram_complete  out  1  last-beat / transaction-done pulse
- sdram_req  out  1  master request
- sdram_write  out  1  1 = write, 0 = read
- sdram_addr  out  ADDR_W  master address
- sdram_wdata  out  DATA_W  master write data
- sdram_byte_enable  out  4  master byte lanes
- sdram_ack  in  1  controller accept pulse
- sdram_rdata  in  DATA_W  controller read data
- sdram_rdvalid  in  1  controller read beat valid
- sdram_complete  in  1  controller read done
- arb_busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: no grant.
  - WR: write granted, waiting for ack.
  - RD: read granted, waiting for ack.
  - RD_DATA: read accepted, waiting for complete.
- IDLE transitions:
  - Only blitw_req → WR.
  - Only blitr_req → RD.
  - Both → the client not granted last (register `last_wr`, reset 0, so the write wins the first tie).
- WR: on sdram_ack → IDLE, set last_wr=1.
- RD: on sdram_ack → RD_DATA, set last_wr=0.
- RD_DATA: on sdram_complete → IDLE.
- Master outputs are combinational from the state:
  - WR: sdram_req=blitw_req, sdram_write=1, addr/wdata/be from the blitw inputs.
  - RD: sdram_req=blitr_req, sdram_write=0, addr from blitr_addr; wdata=0, be=0.
  - IDLE / RD_DATA: sdram_req=0, sdram_write=0, addr=0, wdata=0, be=0.
- Ack routing: blitw_ack=sdram_ack only in WR; blitr_ack=sdram_ack only in RD. An ack in any other state is ignored.
- Read return: blitr_rdata=sdram_rdata always. blitr_rdvalid and blitr_complete mirror sdram_rdvalid and sdram_complete only in RD_DATA; they are forced 0 elsewhere.
- A read beat and complete in the same cycle are both forwarded, and the FSM goes to IDLE.
- Ordering: one transaction at a time, so a write issued after a read never overtakes that read's data.
- No request is ever dropped. A client holding req is granted within one other-client transaction.

## Timing
- Grant latency: client req first high at cycle N in IDLE → state and sdram_req at N+1.
- The ack pass-through is zero-cycle: a controller ack at cycle M drives the client ack at cycle M, and the FSM is in IDLE at M+1.
- Back-to-back writes: ack at M, next grant at M+1, sdram_req at M+2. Minimum 2 cycles per write with a 1-cycle controller.
- Reset values: state=IDLE, last_wr=0, every output 0 (blitr_rdata follows sdram_rdata).
- Reset mid-transaction: the FSM returns to IDLE and any in-flight read is abandoned. The controller and clients are reset in the same cycle.
- A client dropping req before ack is illegal. The arbiter stays in WR/RD with sdram_req=0 until req returns (bench asserts this never happens).

## Structure
- Package `blit_pkg`: `typedef enum logic [1:0] {ARB_IDLE, ARB_WR, ARB_RD, ARB_RD_DATA} arb_state_t;` and the ADDR_W/DATA_W constants.
- Single flat module with one registered FSM plus a combinational mux; no sub-modules.

## Test plan
- Single write: addr=0x0000100, wdata=0xDEADBEEF, be=0xF, controller acks after 3 cycles → one sdram_req with write=1, blitw_ack a single pulse in the ack cycle, FSM IDLE next cycle.
- Single read: blitr addr=0x0000200, controller acks, then 4 rdvalid beats 0x1..0x4 and complete on the last beat → blitr receives all 4 beats and one complete, arb_busy drops the cycle after complete.
- Contention: both requests high from cycle 0, each held until acked → grant order W, R, W, R…; no write is granted between a read's ack and its complete.
- Spurious ack/rdvalid/complete in IDLE → no client ack or data strobe; state stays IDLE.
- Reset asserted in RD_DATA after 2 of 4 beats → the next cycle shows IDLE, all outputs 0, last_wr=0; a fresh read then completes normally.
- Write stream of 16 with a zero-wait controller → exactly 16 acks, one every 2 cycles, addresses in issue order.
